// File: rtl/dp_pkg.sv
// dp_pkg: shared definitions for the dp_exec instruction responder and the
// initiators that build instructions for it.
//   - default widths and draw block size
//   - opcode values
//   - instruction field positions (LSB of each field)
//   - FSM state encoding (also exposed on dp_exec.dbg_state)
package dp_pkg;

    localparam int DEF_INSTR_WIDTH  = 32;
    localparam int DEF_OPCODE_WIDTH = 3;
    localparam int DEF_ADDR_WIDTH   = 8;
    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_X_WIDTH      = 8;
    localparam int DEF_Y_WIDTH      = 7;
    localparam int DEF_COLOUR_WIDTH = 3;
    localparam int DEF_BLOCK_W      = 4;
    localparam int DEF_BLOCK_H      = 4;

    localparam logic [2:0] OPCODE_NOP      = 3'd0;
    localparam logic [2:0] OPCODE_MEMREAD  = 3'd1;
    localparam logic [2:0] OPCODE_MEMWRITE = 3'd2;
    localparam logic [2:0] OPCODE_DRAW     = 3'd3;

    // Memory instructions: opcode | addr | data
    localparam int OPCODE_LSB  = 0;
    localparam int ADDR_LSB    = 3;
    localparam int DATA_LSB    = 11;
    // Draw instruction: opcode | x | y | colour | plot_en
    localparam int X_LSB       = 3;
    localparam int Y_LSB       = 11;
    localparam int COLOUR_LSB  = 18;
    localparam int PLOT_EN_BIT = 21;
    // First instruction bit not used by any field
    localparam int FIELD_END   = 27;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DECODE  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR      = 3'd3,
        S_DRAW    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/dp_ram.sv
// dp_ram: single-port synchronous word RAM holding ant state.
//   clock  in  clock, all activity on posedge
//   addr   in  word address (shared by read and write)
//   we     in  write enable, wdata stored at addr on the edge
//   wdata  in  write data
//   re     in  read enable, rdata loaded from addr on the edge
//   rdata  out registered read data, valid the cycle after re
// Contents are deliberately not reset.
module dp_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dp_exec.sv
// dp_exec: responder for the start/finished instruction handshake. Decodes one
// instruction per handshake and runs a RAM read, a RAM write, a block draw to
// the VGA plot interface, or a no-op.
//   clock        in  clock, all logic on posedge
//   reset        in  asynchronous active-high reset
//   start        in  request from the initiator (may be held high)
//   instruction  in  instruction word, sampled only at accept
//   finished     out 1 = idle/done, 0 = busy
//   result       out data of the last completed MEMREAD
//   illegal_op   out one-cycle pulse for opcodes 4..7
//   vga_x/vga_y  out pixel coordinates
//   vga_colour   out pixel colour
//   vga_plot     out pixel write strobe
//   dbg_state    out current FSM state
//
// Handshake: an instruction is accepted on a clock edge where start is high,
// start was low on the previous edge, and the FSM is IDLE. finished drops on
// that edge and rises on the edge the operation completes. A start held high
// gives one accept; a rising start while busy (including on the edge where
// finished returns) is dropped, so the initiator must lower and re-raise it.
module dp_exec
    import dp_pkg::*;
#(
    parameter int INSTR_WIDTH  = DEF_INSTR_WIDTH,
    parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int X_WIDTH      = DEF_X_WIDTH,
    parameter int Y_WIDTH      = DEF_Y_WIDTH,
    parameter int COLOUR_WIDTH = DEF_COLOUR_WIDTH,
    parameter int BLOCK_W      = DEF_BLOCK_W,
    parameter int BLOCK_H      = DEF_BLOCK_H
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [INSTR_WIDTH-1:0]  instruction,
    output logic                    finished,
    output logic [DATA_WIDTH-1:0]   result,
    output logic                    illegal_op,
    output logic [X_WIDTH-1:0]      vga_x,
    output logic [Y_WIDTH-1:0]      vga_y,
    output logic [COLOUR_WIDTH-1:0] vga_colour,
    output logic                    vga_plot,
    output state_t                  dbg_state
);

    localparam int DX_W = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
    localparam int DY_W = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;

    state_t state, state_n;
    logic   start_q;
    logic   accept;

    logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
    logic                    finished_d;
    logic [DATA_WIDTH-1:0]   result_d;
    logic                    illegal_d;
    logic [X_WIDTH-1:0]      vga_x_d;
    logic [Y_WIDTH-1:0]      vga_y_d;
    logic [COLOUR_WIDTH-1:0] vga_colour_d;
    logic                    vga_plot_d;
    logic [DX_W-1:0]         dx_q, dx_d;
    logic [DY_W-1:0]         dy_q, dy_d;
    logic                    ram_we, ram_re;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    // Fields of the latched instruction
    logic [OPCODE_WIDTH-1:0] op;
    logic [ADDR_WIDTH-1:0]   f_addr;
    logic [DATA_WIDTH-1:0]   f_data;
    logic [X_WIDTH-1:0]      f_x;
    logic [Y_WIDTH-1:0]      f_y;
    logic [COLOUR_WIDTH-1:0] f_colour;
    logic                    f_plot;
    logic                    draw_last;
    logic                    unused_instr_bits;

    assign op       = instr_q[OPCODE_LSB +: OPCODE_WIDTH];
    assign f_addr   = instr_q[ADDR_LSB +: ADDR_WIDTH];
    assign f_data   = instr_q[DATA_LSB +: DATA_WIDTH];
    assign f_x      = instr_q[X_LSB +: X_WIDTH];
    assign f_y      = instr_q[Y_LSB +: Y_WIDTH];
    assign f_colour = instr_q[COLOUR_LSB +: COLOUR_WIDTH];
    assign f_plot   = instr_q[PLOT_EN_BIT];
    assign unused_instr_bits = ^instr_q[INSTR_WIDTH-1:FIELD_END];

    assign draw_last = (dx_q == DX_W'(BLOCK_W - 1)) && (dy_q == DY_W'(BLOCK_H - 1));
    assign accept    = start && !start_q && (state == S_IDLE);
    assign dbg_state = state;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (accept) state_n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OPCODE_WIDTH'(OPCODE_MEMREAD):  state_n = S_RD_WAIT;
                    OPCODE_WIDTH'(OPCODE_MEMWRITE): state_n = S_WR;
                    OPCODE_WIDTH'(OPCODE_DRAW):     state_n = S_DRAW;
                    default:                        state_n = S_DONE;
                endcase
            end
            S_RD_WAIT, S_WR, S_DONE: state_n = S_IDLE;
            S_DRAW:   if (draw_last) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and RAM controls.
    // WR and DONE already report finished=1 (set on the decode edge); the FSM
    // only returns to IDLE one edge later.
    always_comb begin
        instr_d      = instr_q;
        finished_d   = finished;
        result_d     = result;
        illegal_d    = 1'b0;
        vga_x_d      = vga_x;
        vga_y_d      = vga_y;
        vga_colour_d = vga_colour;
        vga_plot_d   = vga_plot;
        dx_d         = dx_q;
        dy_d         = dy_q;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    instr_d    = instruction;
                    finished_d = 1'b0;
                end
            end
            S_DECODE: begin
                case (op)
                    OPCODE_WIDTH'(OPCODE_MEMREAD): ram_re = 1'b1;
                    OPCODE_WIDTH'(OPCODE_MEMWRITE): begin
                        ram_we     = 1'b1;
                        finished_d = 1'b1;
                    end
                    OPCODE_WIDTH'(OPCODE_DRAW): begin
                        // Present pixel 0 of the block
                        dx_d         = '0;
                        dy_d         = '0;
                        vga_x_d      = f_x;
                        vga_y_d      = f_y;
                        vga_colour_d = f_colour;
                        vga_plot_d   = f_plot;
                    end
                    default: begin
                        finished_d = 1'b1;
                        illegal_d  = (op != OPCODE_WIDTH'(OPCODE_NOP));
                    end
                endcase
            end
            S_RD_WAIT: begin
                result_d   = ram_rdata;
                finished_d = 1'b1;
            end
            S_DRAW: begin
                if (draw_last) begin
                    vga_plot_d = 1'b0;
                    finished_d = 1'b1;
                end else begin
                    // Row-major walk; coordinates wrap at their widths
                    if (dx_q == DX_W'(BLOCK_W - 1)) begin
                        dx_d = '0;
                        dy_d = dy_q + 1'b1;
                    end else begin
                        dx_d = dx_q + 1'b1;
                    end
                    vga_x_d = f_x + X_WIDTH'(dx_d);
                    vga_y_d = f_y + Y_WIDTH'(dy_d);
                end
            end
            default: ;
        endcase
    end

    // Datapath / output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_q    <= 1'b0;
            instr_q    <= '0;
            finished   <= 1'b1;
            result     <= '0;
            illegal_op <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            dx_q       <= '0;
            dy_q       <= '0;
        end else begin
            start_q    <= start;
            instr_q    <= instr_d;
            finished   <= finished_d;
            result     <= result_d;
            illegal_op <= illegal_d;
            vga_x      <= vga_x_d;
            vga_y      <= vga_y_d;
            vga_colour <= vga_colour_d;
            vga_plot   <= vga_plot_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
        end
    end

    dp_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clock (clock),
        .addr  (f_addr),
        .we    (ram_we),
        .wdata (f_data),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dp_exec.sv
// tb_dp_exec: directed test of dp_exec with hand-computed expectations.
module tb_dp_exec;

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic [31:0]    instruction;
    logic           finished;
    logic [15:0]    result;
    logic           illegal_op;
    logic [7:0]     vga_x;
    logic [6:0]     vga_y;
    logic [2:0]     vga_colour;
    logic           vga_plot;
    dp_pkg::state_t dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    dp_exec dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .instruction (instruction),
        .finished    (finished),
        .result      (result),
        .illegal_op  (illegal_op),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .dbg_state   (dbg_state)
    );

    // Instruction builders, laid out independently of the design package
    function automatic logic [31:0] mk_rd(input logic [7:0] a);
        return {21'b0, a, 3'd1};
    endfunction

    function automatic logic [31:0] mk_wr(input logic [7:0] a, input logic [15:0] d);
        return {5'b0, d, a, 3'd2};
    endfunction

    function automatic logic [31:0] mk_draw(input logic [7:0] x, input logic [6:0] y,
                                            input logic [2:0] c, input logic p);
        return {10'b0, p, c, y, x, 3'd3};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Raise start for one edge (E0); returns at E0+1 with start low
    task automatic issue(input logic [31:0] instr);
        instruction = instr;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [7:0] a, input logic [15:0] d);
        issue(mk_wr(a, d));
        check({tag, "_busy"}, 32'(finished), 32'd0);
        tick();
        check({tag, "_done"}, 32'(finished), 32'd1);
        tick();
        tick();
    endtask

    task automatic do_read(input string tag, input logic [7:0] a, input logic [15:0] exp);
        issue(mk_rd(a));
        check({tag, "_busy0"}, 32'(finished), 32'd0);
        tick();
        check({tag, "_busy1"}, 32'(finished), 32'd0);
        tick();
        check({tag, "_done"}, 32'(finished), 32'd1);
        check({tag, "_data"}, 32'(result), 32'(exp));
        tick();
    endtask

    // Walk a whole block draw; optionally raise a second start mid-draw
    task automatic run_draw(input string tag, input logic [7:0] x, input logic [6:0] y,
                            input logic [2:0] c, input logic p, input bit inject);
        logic [7:0] ex;
        logic [6:0] ey;
        issue(mk_draw(x, y, c, p));
        for (int k = 0; k < 16; k++) begin
            tick();
            ex = x + 8'(k % 4);
            ey = y + 7'(k / 4);
            check($sformatf("%s_px%0d", tag, k),
                  32'({finished, vga_plot, vga_x, vga_y, vga_colour}),
                  32'({1'b0, p, ex, ey, c}));
            if (inject && k == 3) begin
                instruction = mk_wr(8'h20, 16'h7777);
                start = 1'b1;
            end
            if (inject && k == 5) start = 1'b0;
        end
        tick();
        check({tag, "_end"}, 32'({finished, vga_plot}), 32'd2);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        instruction = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_finished", 32'(finished), 32'd1);
        check("rst_result", 32'(result), 32'd0);
        check("rst_illegal", 32'(illegal_op), 32'd0);
        check("rst_vga", 32'({vga_plot, vga_x, vga_y, vga_colour}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(dp_pkg::S_IDLE));
        reset = 1'b0;
        tick();

        // Write then read back
        do_write("wr12", 8'h12, 16'hBEEF);
        do_read("rd12", 8'h12, 16'hBEEF);

        // Start held for 5 edges; instruction changes after accept
        do_write("wr14", 8'h14, 16'h5555);
        instruction = mk_wr(8'h13, 16'hA5A5);
        start = 1'b1;
        tick();
        check("held_busy", 32'(finished), 32'd0);
        instruction = mk_wr(8'h14, 16'h0F0F);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("held_fin_e%0d", i), 32'(finished), 32'd1);
        end
        start = 1'b0;
        tick();
        do_read("held_rd13", 8'h13, 16'hA5A5);
        do_read("held_rd14", 8'h14, 16'h5555);

        // Start rising on the edge finished returns is dropped
        do_write("wr21", 8'h21, 16'h3333);
        issue(mk_rd(8'h21));
        tick();
        instruction = mk_wr(8'h21, 16'h2222);
        start = 1'b1;
        tick();
        check("coinc_done", 32'({finished, result}), 32'({1'b1, 16'h3333}));
        tick();
        start = 1'b0;
        tick();
        tick();
        do_read("coinc_rd21", 8'h21, 16'h3333);

        // Draws: plotted, unplotted with a busy start, wrapping
        do_write("wr20", 8'h20, 16'h1111);
        run_draw("draw_plot", 8'd10, 7'd20, 3'd5, 1'b1, 1'b0);
        run_draw("draw_noplot", 8'd10, 7'd20, 3'd5, 1'b0, 1'b1);
        do_read("busy_rd20", 8'h20, 16'h1111);
        run_draw("draw_wrap", 8'd254, 7'd126, 3'd2, 1'b1, 1'b0);

        // Illegal opcode 6, then NOP
        issue(32'd6);
        check("ill_busy", 32'({finished, illegal_op}), 32'd0);
        tick();
        check("ill_e1", 32'({finished, illegal_op}), 32'd3);
        tick();
        check("ill_e2", 32'({illegal_op, result}), 32'({1'b0, 16'h1111}));
        tick();
        issue(32'd0);
        check("nop_busy", 32'(finished), 32'd0);
        tick();
        check("nop_e1", 32'({finished, illegal_op}), 32'd2);
        tick();
        check("nop_e2", 32'(illegal_op), 32'd0);
        tick();

        // Reset while pixel 5 is presented
        issue(mk_draw(8'd10, 7'd20, 3'd5, 1'b1));
        repeat (6) tick();
        check("mid_px5", 32'({finished, vga_plot, vga_x, vga_y}), 32'({1'b0, 1'b1, 8'd11, 7'd21}));
        reset = 1'b1;
        #1;
        check("mid_rst_out", 32'({finished, vga_plot}), 32'd2);
        check("mid_rst_state", 32'(dbg_state), 32'(dp_pkg::S_IDLE));
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
        do_read("post_rst_rd12", 8'h12, 16'hBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
